// File: rtl/controller_pkg.sv
// controller_pkg: state encodings, opcodes, select and ALU codes shared by the multicycle controller.
package controller_pkg;
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_ILLEGAL  = 4'd15
  } state_e;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [1:0] SRCA_PC  = 2'b00;
  localparam logic [1:0] SRCA_REG = 2'b01;
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: funct3/funct7 decode into an ALU operation and an ALU-op legality flag.
module alu_decoder
  import controller_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       instr30,
  output logic [2:0] alu_control,
  output logic       funct_legal
);
  assign alu_control = instr30 ? ALU_SUB : ALU_ADD;
  assign funct_legal = funct3 == F3_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle RV32 subset datapath (lw, sw, add/sub, addi).
module multicycle_controller
  import controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] instr,
  output logic        mem_write,
  output logic        reg_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        instruction_or_data,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_control,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [3:0]  state_out
);
  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic [2:0]  dec_alu;
  logic        funct_legal;
  logic [6:0]  opcode;
  logic        retire;
  assign opcode = instr[6:0];
  alu_decoder u_alu_decoder (
    .funct3      (instr[14:12]),
    .instr30     (instr[30]),
    .alu_control (dec_alu),
    .funct_legal (funct_legal)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end
  // every writeback/store state always leaves on the next edge, so it retires there
  assign retire    = state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB};
  assign instret_d = retire ? instret_q + 32'd1 : instret_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = run ? S_FETCH : S_IDLE;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:   state_d = ((opcode == OP_LOAD || opcode == OP_STORE) && instr[14:12] == F3_WORD) ? S_MEMADR :
                            (opcode == OP_RTYPE && funct_legal) ? S_EXECR :
                            (opcode == OP_ITYPE && funct_legal) ? S_EXECI : S_ILLEGAL;
      S_MEMADR:   state_d = opcode == OP_STORE ? S_MEMWRITE : opcode == OP_LOAD ? S_MEMREAD : S_ILLEGAL;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_MEMWB,
      S_MEMWRITE,
      S_ALUWB:    state_d = run ? S_FETCH : S_IDLE;
      default:    state_d = S_ILLEGAL;
    endcase
  end
  always_comb begin
    mem_write           = 1'b0;
    reg_write           = 1'b0;
    ir_write            = 1'b0;
    pc_write            = 1'b0;
    instruction_or_data = 1'b0;
    result_src          = RES_ALUOUT;
    alu_src_a           = SRCA_PC;
    alu_src_b           = SRCB_REG;
    alu_control         = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = SRCB_4;
        result_src = RES_ALU;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  instruction_or_data = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write           = 1'b1;
        instruction_or_data = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = SRCA_REG;
        alu_control = dec_alu;
      end
      S_EXECI: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
      end
      S_ALUWB:    reg_write = 1'b1;
      default:    ;
    endcase
  end
  assign illegal   = state_q == S_ILLEGAL;
  assign instret   = instret_q;
  assign state_out = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction streams checked against a per-instruction path model.
module tb_multicycle_controller;
  logic        clk = 1'b0;
  logic        reset, run;
  logic [31:0] instr;
  logic        mem_write, reg_write, ir_write, pc_write, instruction_or_data, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [2:0]  alu_control;
  logic [31:0] instret;
  logic [3:0]  state_out;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_instret = 0;
  multicycle_controller dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr),
    .mem_write(mem_write), .reg_write(reg_write), .ir_write(ir_write), .pc_write(pc_write),
    .instruction_or_data(instruction_or_data), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .illegal(illegal), .instret(instret), .state_out(state_out)
  );
  always #5 clk = ~clk;
  wire [14:0] got_out = {mem_write, reg_write, ir_write, pc_write, instruction_or_data,
                         result_src, alu_src_a, alu_src_b, alu_control, illegal};
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // {mem_write, reg_write, ir_write, pc_write, iod, result_src, alu_src_a, alu_src_b, alu_control, illegal}
  function automatic logic [14:0] exp_out(int st, logic [31:0] ins);
    logic mw = 0, rw = 0, irw = 0, pcw = 0, iod = 0, ill = 0;
    logic [1:0] res = 0, sa = 0, sb = 0;
    logic [2:0] alu = 0;
    if (st == 1) begin irw = 1; pcw = 1; sb = 2'b01; res = 2'b10; end
    if (st == 3) begin sa = 2'b01; sb = 2'b10; end
    if (st == 4) iod = 1;
    if (st == 5) begin res = 2'b01; rw = 1; end
    if (st == 6) begin mw = 1; iod = 1; end
    if (st == 7) begin sa = 2'b01; alu = ins[30] ? 3'b001 : 3'b000; end
    if (st == 8) begin sa = 2'b01; sb = 2'b10; end
    if (st == 9) rw = 1;
    if (st == 15) ill = 1;
    return {mw, rw, irw, pcw, iod, res, sa, sb, alu, ill};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_state(string tag, int st, logic [31:0] ins);
    check($sformatf("%s state", tag), {28'd0, state_out}, st);
    check($sformatf("%s outputs", tag), {17'd0, got_out}, {17'd0, exp_out(st, ins)});
    check($sformatf("%s instret", tag), instret, exp_instret);
  endtask
  task automatic enter_fetch();
    repeat ($urandom_range(0, 3)) begin
      run = 1'b0;
      check_state("idle", 0, instr);
      tick();
    end
    run = 1'b1;
    check_state("idle_go", 0, instr);
    tick();
  endtask
  // pulse reset between edges so the return to IDLE must happen without a clock
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    exp_instret = 0;
    check_state("async_reset", 0, instr);
    tick();
    reset = 1'b0;
    check_state("after_reset", 0, instr);
  endtask
  // kind: 0 lw, 1 sw, 2 addi, 3 add/sub, 4 illegal; entered with the DUT in FETCH
  task automatic exec(logic [31:0] ins, int kind, bit run_end);
    int path[$];
    case (kind)
      0: path = '{1, 2, 3, 4, 5};
      1: path = '{1, 2, 3, 6};
      2: path = '{1, 2, 8, 9};
      3: path = '{1, 2, 7, 9};
      default: path = '{1, 2, 15};
    endcase
    instr = ins;
    foreach (path[i]) begin
      run = (i == path.size() - 1 && kind != 4) ? run_end : 1'($urandom);
      check_state($sformatf("k%0d st%0d", kind, path[i]), path[i], ins);
      tick();
    end
    if (kind == 4) begin
      repeat (20) begin
        run = 1'($urandom);
        check_state("illegal_hold", 15, ins);
        tick();
      end
      pulse_reset();
      enter_fetch();
    end else begin
      exp_instret++;
      if (!run_end) enter_fetch();
    end
  endtask
  function automatic logic [31:0] gen(int kind);
    logic [31:0] r = $urandom;
    case (kind)
      0: begin r[6:0] = 7'b0000011; r[14:12] = 3'b010; end
      1: begin r[6:0] = 7'b0100011; r[14:12] = 3'b010; end
      2: begin r[6:0] = 7'b0010011; r[14:12] = 3'b000; end
      3: begin r[6:0] = 7'b0110011; r[14:12] = 3'b000; end
      default: begin
        case ($urandom_range(0, 2))
          0: r[6:0] = 7'b1101111;
          1: begin
            r[6:0] = $urandom_range(0, 1) ? 7'b0000011 : 7'b0100011;
            r[14:12] = 3'($urandom_range(3, 9));
          end
          default: begin
            r[6:0] = $urandom_range(0, 1) ? 7'b0110011 : 7'b0010011;
            r[14:12] = 3'($urandom_range(1, 7));
          end
        endcase
      end
    endcase
    return r;
  endfunction
  initial begin
    reset = 1'b1;
    run   = 1'b1;
    instr = 32'h0;
    #1;
    check_state("in_reset", 0, instr);
    tick();
    reset = 1'b0;
    run   = 1'b0;
    tick();
    check_state("post_reset_idle", 0, instr);
    enter_fetch();
    exec(32'h00500093, 2, 1'b1);
    exec(32'h00402103, 0, 1'b1);
    exec(32'h00202223, 1, 1'b1);
    exec(32'h402081B3, 3, 1'b1);
    exec(32'h00500093, 2, 1'b0);
    exec(32'h0000006F, 4, 1'b1);
    for (int i = 0; i < 300; i++) begin
      int kind = ($urandom_range(0, 15) == 0) ? 4 : int'($urandom_range(0, 3));
      exec(gen(kind), kind, 1'($urandom_range(0, 3) != 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
